// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS phase generator.
// Includes the step-to-tuning-word helper.
package dds_pkg;

  localparam int DDS_ACC_W  = 24;
  localparam int DDS_ADDR_W = 6;
  localparam int DDS_DIV_W  = 8;

  localparam logic [DDS_ACC_W-1:0] DDS_TW_RESET = 24'h040000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_t;

  function automatic logic [DDS_ACC_W-1:0] tw_for_step(
    input logic [DDS_ADDR_W-1:0] step
  );
    logic [DDS_ACC_W-1:0] w;
    w = DDS_ACC_W'(step);
    return w << (DDS_ACC_W - DDS_ADDR_W);
  endfunction

endpackage

// File: rtl/dds_phase_gen_if.sv
// Tuning-word handshake and ROM strobe bundle.
// The slave side is the phase generator.
interface dds_phase_gen_if #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 6
);

  logic [ACC_W-1:0]  tw_data;
  logic              tw_valid;
  logic              tw_ready;
  logic              tw_busy;
  logic [ADDR_W-1:0] addr;
  logic              addr_en;
  logic              cycle_start;

  modport master (
    output tw_data, tw_valid,
    input  tw_ready, tw_busy,
    input  addr, addr_en, cycle_start
  );

  modport slave (
    input  tw_data, tw_valid,
    output tw_ready, tw_busy,
    output addr, addr_en, cycle_start
  );

endinterface

// File: rtl/dds_tick_div.sv
// Sample-rate divider: one tick every div+1 enabled cycles.
// Counter is held at zero while disabled.
module dds_tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == div);

  // Lowering div below cnt simply lets cnt run round 2^DIV_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dds_phase_gen.sv
// Phase accumulator driving sine ROM address/strobe, with
// tuning-word updates deferred to the next phase wrap.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int ACC_W  = DDS_ACC_W,
  parameter int ADDR_W = DDS_ADDR_W,
  parameter int DIV_W  = DDS_DIV_W,
  parameter logic [ACC_W-1:0] TW_RESET = DDS_TW_RESET
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  dds_phase_gen_if.slave   bus
);

  state_t            state;
  logic [ACC_W-1:0]  phase;
  logic [ACC_W-1:0]  tw_active;
  logic [ACC_W-1:0]  tw_pending;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_en_q;
  logic              cyc_q;
  logic [ACC_W:0]    sum;
  logic              tick;
  logic              accept;
  logic              apply;

  dds_tick_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .div   (div),
    .tick  (tick)
  );

  assign sum    = {1'b0, phase} + {1'b0, tw_active};
  assign accept = bus.tw_valid && bus.tw_ready;
  // A zero word can never carry, so it yields on the next tick.
  assign apply  = tick && (sum[ACC_W] || (tw_active == '0));

  assign bus.tw_ready    = (state != PEND);
  assign bus.tw_busy     = (state == PEND);
  assign bus.addr        = addr_q;
  assign bus.addr_en     = addr_en_q;
  assign bus.cycle_start = cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      tw_active  <= TW_RESET;
      tw_pending <= '0;
      addr_q     <= '0;
      addr_en_q  <= 1'b0;
      cyc_q      <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      phase     <= '0;
      addr_q    <= '0;
      addr_en_q <= 1'b0;
      cyc_q     <= 1'b0;
      if (state == PEND) begin
        tw_active <= tw_pending;
      end else if (accept) begin
        tw_active <= bus.tw_data;
      end
    end else begin
      addr_en_q <= tick;
      cyc_q     <= tick && sum[ACC_W];
      if (tick) begin
        phase  <= sum[ACC_W-1:0];
        addr_q <= sum[ACC_W-1 -: ADDR_W];
      end
      unique case (state)
        IDLE: begin
          state <= RUN;
          if (accept) begin
            tw_active <= bus.tw_data;
          end
        end
        RUN: begin
          if (accept) begin
            tw_pending <= bus.tw_data;
            state      <= PEND;
          end
        end
        PEND: begin
          if (apply) begin
            tw_active <= tw_pending;
            state     <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen with hand-derived
// expected address/strobe sequences.
module tb_dds_phase_gen;
  import dds_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div = 8'd0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  dds_phase_gen_if #(.ACC_W(24), .ADDR_W(6)) bus ();

  dds_phase_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .div   (div),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, ".addr"}, 32'(bus.addr), 32'd0);
    chk({tag, ".addr_en"}, 32'(bus.addr_en), 32'd0);
    chk({tag, ".cyc"}, 32'(bus.cycle_start), 32'd0);
    chk({tag, ".ready"}, 32'(bus.tw_ready), 32'd1);
    chk({tag, ".busy"}, 32'(bus.tw_busy), 32'd0);
  endtask

  initial begin
    bus.tw_valid = 1'b0;
    bus.tw_data  = '0;
    #2;
    chk_idle_out("reset");
    step();
    rst_n = 1'b1;
    step();
    chk("idle.addr_en", 32'(bus.addr_en), 32'd0);

    // div=0, default word: one address per cycle, wrap at 64
    en = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step();
      chk("run.addr", 32'(bus.addr), 32'(k % 64));
      chk("run.addr_en", 32'(bus.addr_en), 32'd1);
      chk("run.cyc", 32'(bus.cycle_start), 32'(k == 64));
    end

    // div=2: strobe every third cycle
    en = 1'b0;
    step();
    chk("stop.addr", 32'(bus.addr), 32'd0);
    chk("stop.addr_en", 32'(bus.addr_en), 32'd0);
    div = 8'd2;
    en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("div2.addr_en", 32'(bus.addr_en), 32'(k % 3 == 0));
      chk("div2.addr", 32'(bus.addr), 32'(k / 3));
    end

    // new word offered at addr=10, applied at wrap
    en = 1'b0;
    div = 8'd0;
    step();
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("pre.addr", 32'(bus.addr), 32'(k));
    end
    bus.tw_valid = 1'b1;
    bus.tw_data  = tw_for_step(6'd4);
    step();
    bus.tw_valid = 1'b0;
    chk("acc.addr", 32'(bus.addr), 32'd11);
    chk("acc.ready", 32'(bus.tw_ready), 32'd0);
    chk("acc.busy", 32'(bus.tw_busy), 32'd1);
    for (int k = 12; k <= 63; k++) begin
      step();
      chk("pend.addr", 32'(bus.addr), 32'(k));
    end
    chk("pend.busy", 32'(bus.tw_busy), 32'd1);
    step();
    chk("wrap.addr", 32'(bus.addr), 32'd0);
    chk("wrap.cyc", 32'(bus.cycle_start), 32'd1);
    chk("wrap.ready", 32'(bus.tw_ready), 32'd1);
    chk("wrap.busy", 32'(bus.tw_busy), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("step4.addr", 32'(bus.addr), 32'(4 * k));
      chk("step4.cyc", 32'(bus.cycle_start), 32'd0);
    end

    // zero word loaded while stopped; frozen phase
    en = 1'b0;
    bus.tw_valid = 1'b1;
    bus.tw_data  = '0;
    step();
    bus.tw_valid = 1'b0;
    en = 1'b1;
    step();
    chk("frz1.addr", 32'(bus.addr), 32'd0);
    chk("frz1.addr_en", 32'(bus.addr_en), 32'd1);
    bus.tw_valid = 1'b1;
    bus.tw_data  = tw_for_step(6'd1);
    step();
    bus.tw_valid = 1'b0;
    chk("frz2.addr", 32'(bus.addr), 32'd0);
    chk("frz2.busy", 32'(bus.tw_busy), 32'd1);
    step();
    chk("frz3.addr", 32'(bus.addr), 32'd0);
    chk("frz3.busy", 32'(bus.tw_busy), 32'd0);
    step();
    chk("frz4.addr", 32'(bus.addr), 32'd1);

    // en drops with a word pending; word survives
    bus.tw_valid = 1'b1;
    bus.tw_data  = tw_for_step(6'd2);
    step();
    bus.tw_valid = 1'b0;
    chk("pd.addr", 32'(bus.addr), 32'd2);
    chk("pd.busy", 32'(bus.tw_busy), 32'd1);
    en = 1'b0;
    step();
    chk_idle_out("drop");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("low.addr_en", 32'(bus.addr_en), 32'd0);
      chk("low.addr", 32'(bus.addr), 32'd0);
    end
    en = 1'b1;
    step();
    chk("re1.addr", 32'(bus.addr), 32'd2);
    chk("re1.addr_en", 32'(bus.addr_en), 32'd1);
    step();
    chk("re2.addr", 32'(bus.addr), 32'd4);

    // async reset mid-cycle while a word is pending
    bus.tw_valid = 1'b1;
    bus.tw_data  = tw_for_step(6'd5);
    step();
    bus.tw_valid = 1'b0;
    chk("pr.busy", 32'(bus.tw_busy), 32'd1);
    chk("pr.addr", 32'(bus.addr), 32'd6);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle_out("arst");
    #2;
    rst_n = 1'b1;
    step();
    chk("post1.addr", 32'(bus.addr), 32'd1);
    chk("post1.addr_en", 32'(bus.addr_en), 32'd1);
    step();
    chk("post2.addr", 32'(bus.addr), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_phase_gen.md
Name: dds_phase_gen

Overview:
- Phase-accumulator address generator that feeds the sine ROM / DAC chain.
- Replaces the free-running address counter and tick counter with a programmable tuning word, applied glitch-free at phase wrap, and an integrated sample-rate divider.
- Runs in the 300 MHz PLL domain. Drives ROM `addr` and ROM `en` directly.

Parameters:
- ACC_W, 24, phase accumulator width in bits.
- ADDR_W, 6, ROM address width; `addr` = top ADDR_W bits of phase.
- DIV_W, 8, sample-rate divider width.
- TW_RESET, 24'h040000, active tuning word after reset (+1 address per tick).

Ports:
- clk  in  1  single clock (PLL 300 MHz output).
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable (tie to PLL `locked`).
- div  in  DIV_W  tick period minus 1; sampled continuously.
- tw_data  in  ACC_W  new tuning word.
- tw_valid  in  1  `tw_data` offered.
- tw_ready  out  1  block can accept a tuning word.
- addr  out  ADDR_W  ROM address.
- addr_en  out  1  one-cycle strobe; ROM reads `addr` this cycle.
- cycle_start  out  1  one-cycle pulse with `addr_en` when the accumulator wraps.
- tw_busy  out  1  pending word not yet applied.

Behaviour:
- Reset (async, `rst_n`=0):
  - phase=0, tick_cnt=0, tw_active=TW_RESET, tw_pending=0.
  - `addr`=0, `addr_en`=0, `cycle_start`=0, `tw_busy`=0, `tw_ready`=1.
  - FSM=IDLE.
- FSM states:
  - IDLE: `en`=0. phase and tick_cnt held at 0, no strobes.
  - RUN: `en`=1, no pending word.
  - PEND: `en`=1, word pending.
- Transitions:
  - IDLE->RUN when `en`=1.
  - RUN->PEND on accept.
  - PEND->RUN on apply.
  - Any state->IDLE when `en`=0. This clears phase and tick_cnt next cycle; `addr` returns to 0.
- Tick generation:
  - tick_cnt counts 0..div.
  - Tick when tick_cnt==div; tick_cnt then returns to 0.
  - `div`=0 gives a tick every cycle.
  - If `div` is lowered below tick_cnt, tick_cnt wraps at 2^DIV_W. Accepted; no protection.
- On a tick, in the same registered edge:
  - {carry, phase} <= phase + tw_active. Unsigned, ACC_W bits, carry discarded from phase.
  - `addr` <= new phase[ACC_W-1 -: ADDR_W].
  - `addr_en` <= 1.
  - `cycle_start` <= carry.
- Latency: `addr`/`addr_en` valid on the cycle after the tick condition. First `addr_en` after IDLE->RUN occurs div+1 cycles after `en` rises.
- Handshake:
  - Transfer when `tw_valid` and `tw_ready` are both high on a clock edge.
  - `tw_ready` = 1 in IDLE and RUN, 0 in PEND.
  - `tw_busy` = (state==PEND).
- Apply rules:
  - In IDLE, an accepted word goes straight to tw_active on the next edge. No PEND.
  - In PEND, the word is applied on the first tick whose addition produces a carry. That sum uses the old tw_active; the new word is used from the following tick.
  - If tw_active==0 (frozen phase, no carry possible), the pending word applies on the next tick.
  - `tw_ready` returns high the cycle after apply. A `tw_valid` held high is accepted on that cycle.
- `en` falls while PEND: the pending word is applied to tw_active on entry to IDLE, not lost.
- `addr_en` and `cycle_start` are never high outside RUN/PEND.

Decomposition:
- Package dds_pkg:
  - state enum {IDLE, RUN, PEND}.
  - Default ACC_W/ADDR_W constants.
  - TW_RESET.
  - Helper function tw_for_step(step) = step << (ACC_W-ADDR_W).
- One sub-module: dds_tick_div (tick_cnt, `div`, `en` -> tick).
- Accumulator and FSM stay in the top.

Test Plan:
- Reset, then `en`=1, `div`=0, default TW -> `addr` runs 1,2,...,63,0. `addr_en` high every cycle. `cycle_start` high exactly with `addr`=0, every 64 ticks.
- `div`=2 -> `addr_en` pulses every 3rd cycle. First strobe 3 cycles after `en` rises. `addr` increments by 1 per strobe.
- In RUN, offer TW=24'h100000 at `addr`=10 -> `tw_ready` drops next cycle; `tw_busy`=1. Step stays +1 until the wrap (`addr`=0, `cycle_start`=1). Then `addr` runs 4,8,12; `tw_ready`=1 again.
- TW=0 active, offer 24'h040000 -> `addr` frozen. New word applied on the next tick; `addr` advances by 1 on the tick after.
- Drop `en` mid-run with a word pending, then re-raise -> `addr`=0, no strobes while low. New TW active immediately on restart.
- Assert `rst_n`=0 asynchronously mid-tick -> all outputs 0 and `tw_ready`=1 immediately, without a clock edge. tw_active back to TW_RESET.
